// File: rtl/stage_id_pipe_if.sv
// stage_id_pipe_if: ID/EX bus between stage_id_pipe (master) and stage_ex (slave).
interface stage_id_pipe_if #(
  parameter int XLEN = 32,
  parameter int REG_AW = 5,
  parameter int ALUOP_W = 8,
  parameter int ALUSEL_W = 3
);
  logic out_valid, out_ready, we, illegal;
  logic [ALUOP_W-1:0] aluop;
  logic [ALUSEL_W-1:0] alusel;
  logic [XLEN-1:0] opv1, opv2, imm, pc_out;
  logic [REG_AW-1:0] reg_waddr;
  modport master (
    output out_valid, aluop, alusel, opv1, opv2, imm, reg_waddr, we, pc_out, illegal,
    input out_ready
  );
  modport slave (
    input out_valid, aluop, alusel, opv1, opv2, imm, reg_waddr, we, pc_out, illegal,
    output out_ready
  );
endinterface

// File: rtl/stage_id_pipe.sv
// stage_id_pipe: registered RV32I decode (OP_IMM/OP/LUI/AUIPC/LOAD/STORE) with a valid/ready ID/EX register.
// STAGE_ID_FWD_EN enables EX/MEM forwarding; without it any RAW against EX/MEM stalls.
module stage_id_pipe #(
  parameter int XLEN = 32,
  parameter int REG_AW = 5,
  parameter int ALUOP_W = 8,
  parameter int ALUSEL_W = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic [XLEN-1:0] pc,
  input  logic [31:0] inst,
  input  logic flush,
  output logic re1,
  output logic re2,
  output logic [REG_AW-1:0] reg_addr1,
  output logic [REG_AW-1:0] reg_addr2,
  input  logic [XLEN-1:0] reg_data1,
  input  logic [XLEN-1:0] reg_data2,
  input  logic ex_we,
  input  logic ex_is_load,
  input  logic [REG_AW-1:0] ex_reg_waddr,
  input  logic [XLEN-1:0] ex_reg_wdata,
  input  logic mem_we,
  input  logic [REG_AW-1:0] mem_reg_waddr,
  input  logic [XLEN-1:0] mem_reg_wdata,
  stage_id_pipe_if.master idex
);
  localparam logic [6:0] OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011, OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111, OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011;
  // Same values as the EXE_*_OP / EXE_RES_* encodings consumed by stage_ex
  localparam logic [ALUOP_W-1:0] OP_NOP = ALUOP_W'(8'h00), OP_ADD = ALUOP_W'(8'h20), OP_SUB = ALUOP_W'(8'h22);
  localparam logic [ALUOP_W-1:0] OP_AND = ALUOP_W'(8'h24), OP_OR = ALUOP_W'(8'h25), OP_XOR = ALUOP_W'(8'h26);
  localparam logic [ALUOP_W-1:0] OP_SLT = ALUOP_W'(8'h2A), OP_SLTU = ALUOP_W'(8'h2B), OP_SLL = ALUOP_W'(8'h7C);
  localparam logic [ALUOP_W-1:0] OP_SRL = ALUOP_W'(8'h02), OP_SRA = ALUOP_W'(8'h03);
  localparam logic [ALUOP_W-1:0] OP_LB = ALUOP_W'(8'hE0), OP_SB = ALUOP_W'(8'hE8);
  localparam logic [ALUSEL_W-1:0] SEL_NOP = ALUSEL_W'(3'd0), SEL_LOGIC = ALUSEL_W'(3'd1), SEL_SHIFT = ALUSEL_W'(3'd2);
  localparam logic [ALUSEL_W-1:0] SEL_ARITH = ALUSEL_W'(3'd4), SEL_LDST = ALUSEL_W'(3'd7);
  localparam int OPW = ALUOP_W + ALUSEL_W;
  function automatic logic [OPW-1:0] alu_of(input logic [2:0] f, input logic alt);
    case (f)
      3'b000: return {alt ? OP_SUB : OP_ADD, SEL_ARITH};
      3'b001: return {OP_SLL, SEL_SHIFT};
      3'b010: return {OP_SLT, SEL_ARITH};
      3'b011: return {OP_SLTU, SEL_ARITH};
      3'b100: return {OP_XOR, SEL_LOGIC};
      3'b101: return {alt ? OP_SRA : OP_SRL, SEL_SHIFT};
      3'b110: return {OP_OR, SEL_LOGIC};
      default: return {OP_AND, SEL_LOGIC};
    endcase
  endfunction
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [XLEN-1:0] i_imm, s_imm, u_imm, shamt, d_imm, d_alt1, opv1_d, opv2_d;
  logic [OPW-1:0] d_op;
  logic d_we, d_ill, hit1_ex, hit2_ex, hit1_mem, hit2_mem, hazard, cap;
  assign opc = inst[6:0];
  assign f3 = inst[14:12];
  assign f7 = inst[31:25];
  assign i_imm = XLEN'($signed(inst[31:20]));
  assign s_imm = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign u_imm = XLEN'($signed({inst[31:12], 12'b0}));
  assign shamt = XLEN'(inst[24:20]);
  always_comb begin
    {re1, re2, d_we, d_ill} = 4'b0;
    d_op = {OP_NOP, SEL_NOP};
    d_imm = '0;
    d_alt1 = '0;
    case (opc)
      OPC_OPIMM: begin
        {re1, d_we} = 2'b11;
        d_op = alu_of(f3, f3 == 3'b101 && f7[5]);
        d_imm = (f3 == 3'b001 || f3 == 3'b101) ? shamt : i_imm;
        d_ill = f3 == 3'b001 ? f7 != 7'h00 : f3 == 3'b101 ? (f7 & 7'h5F) != 7'h00 : 1'b0;
      end
      OPC_OP: begin
        {re1, re2, d_we} = 3'b111;
        d_op = alu_of(f3, f7[5]);
        d_ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OPC_LUI: begin
        d_we = 1'b1;
        d_op = {OP_ADD, SEL_ARITH};
        d_imm = u_imm;
      end
      OPC_AUIPC: begin
        d_we = 1'b1;
        d_op = {OP_ADD, SEL_ARITH};
        d_imm = u_imm;
        d_alt1 = pc;
      end
      OPC_LOAD: begin
        {re1, d_we} = 2'b11;
        d_op = {OP_LB | ALUOP_W'(f3), SEL_LDST};
        d_imm = i_imm;
        d_ill = f3 == 3'b011 || f3[2:1] == 2'b11;
      end
      OPC_STORE: begin
        {re1, re2} = 2'b11;
        d_op = {OP_SB | ALUOP_W'(f3), SEL_LDST};
        d_imm = s_imm;
        d_ill = f3 > 3'b010;
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      {re1, re2, d_we} = 3'b0;
      d_op = {OP_NOP, SEL_NOP};
      d_imm = '0;
    end
  end
  assign reg_addr1 = re1 ? REG_AW'(inst[19:15]) : '0;
  assign reg_addr2 = re2 ? REG_AW'(inst[24:20]) : '0;
  assign hit1_ex = reg_addr1 != '0 && ex_we && reg_addr1 == ex_reg_waddr;
  assign hit2_ex = reg_addr2 != '0 && ex_we && reg_addr2 == ex_reg_waddr;
  assign hit1_mem = reg_addr1 != '0 && mem_we && reg_addr1 == mem_reg_waddr;
  assign hit2_mem = reg_addr2 != '0 && mem_we && reg_addr2 == mem_reg_waddr;
`ifdef STAGE_ID_FWD_EN
  assign hazard = in_valid && ex_is_load && (hit1_ex || hit2_ex);
  assign opv1_d = !re1 ? d_alt1 : reg_addr1 == '0 ? '0 : hit1_ex ? ex_reg_wdata : hit1_mem ? mem_reg_wdata : reg_data1;
  assign opv2_d = !re2 ? d_imm : reg_addr2 == '0 ? '0 : hit2_ex ? ex_reg_wdata : hit2_mem ? mem_reg_wdata : reg_data2;
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_is_load, ex_reg_wdata, mem_reg_wdata};
  assign hazard = in_valid && (hit1_ex || hit2_ex || hit1_mem || hit2_mem);
  assign opv1_d = !re1 ? d_alt1 : reg_addr1 == '0 ? '0 : reg_data1;
  assign opv2_d = !re2 ? d_imm : reg_addr2 == '0 ? '0 : reg_data2;
`endif
  assign in_ready = (!idex.out_valid || idex.out_ready) && !hazard && !flush;
  assign cap = in_valid && in_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex.out_valid <= 1'b0;
      {idex.aluop, idex.alusel} <= '0;
      idex.opv1 <= '0;
      idex.opv2 <= '0;
      idex.imm <= '0;
      idex.reg_waddr <= '0;
      idex.we <= 1'b0;
      idex.pc_out <= '0;
      idex.illegal <= 1'b0;
    end else if (flush) begin
      idex.out_valid <= 1'b0;
    end else if (cap) begin
      idex.out_valid <= 1'b1;
      {idex.aluop, idex.alusel} <= d_op;
      idex.opv1 <= opv1_d;
      idex.opv2 <= opv2_d;
      idex.imm <= d_imm;
      idex.reg_waddr <= d_we ? REG_AW'(inst[11:7]) : '0;
      idex.we <= d_we;
      idex.pc_out <= pc;
      idex.illegal <= d_ill;
    end else if (idex.out_ready) begin
      idex.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stage_id_pipe.sv
// tb_stage_id_pipe: directed vectors with hand-computed expectations for stage_id_pipe.
module tb_stage_id_pipe;
  localparam logic [31:0] I_ADDI = 32'hFFF00093;
  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_ADD0 = 32'h000001B3;
  localparam logic [31:0] I_SUB = 32'h40728333;
  localparam logic [31:0] I_ORI = 32'hF000E113;
  localparam logic [31:0] I_AUIPC = 32'h12345217;
  localparam logic [31:0] I_SW = 32'hFE20AE23;
  localparam logic [31:0] I_BAD = 32'h0000007F;
  localparam logic [31:0] I_SLLI_BAD = 32'h02309093;
  localparam logic [31:0] I_SRAI = 32'h4030D093;
  localparam logic [7:0] A_ADD = 8'h20, A_SUB = 8'h22;
  logic clk, rst_n, in_valid, in_ready, flush, re1, re2;
  logic [31:0] pc, inst, reg_data1, reg_data2, ex_reg_wdata, mem_reg_wdata;
  logic [4:0] reg_addr1, reg_addr2, ex_reg_waddr, mem_reg_waddr;
  logic ex_we, ex_is_load, mem_we;
  int nvec = 0, nerr = 0;
  stage_id_pipe_if idex ();
  stage_id_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .pc(pc), .inst(inst),
    .flush(flush), .re1(re1), .re2(re2), .reg_addr1(reg_addr1), .reg_addr2(reg_addr2),
    .reg_data1(reg_data1), .reg_data2(reg_data2), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .ex_reg_waddr(ex_reg_waddr), .ex_reg_wdata(ex_reg_wdata), .mem_we(mem_we),
    .mem_reg_waddr(mem_reg_waddr), .mem_reg_wdata(mem_reg_wdata), .idex(idex)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic side_idle();
    {ex_we, ex_is_load, mem_we} = 3'b0;
    ex_reg_waddr = '0;
    mem_reg_waddr = '0;
    ex_reg_wdata = '0;
    mem_reg_wdata = '0;
  endtask
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    inst = '0;
    pc = '0;
    flush = 1'b0;
    reg_data1 = '0;
    reg_data2 = '0;
    idex.out_ready = 1'b1;
    side_idle();
    repeat (2) tick();
    check("rst_valid", idex.out_valid, 0);
    check("rst_opv2", idex.opv2, 0);
    rst_n = 1'b1;
    tick();
    // First instruction after reset: one-cycle latency
    pc = 32'h100;
    inst = I_ADDI;
    in_valid = 1'b1;
    #1;
    check("addi_ready", in_ready, 1);
    check("addi_re", {re2, re1}, 2'b01);
    tick();
    check("addi_valid", idex.out_valid, 1);
    check("addi_opv1", idex.opv1, 0);
    check("addi_opv2", idex.opv2, 32'hFFFFFFFF);
    check("addi_waddr", idex.reg_waddr, 1);
    check("addi_we", idex.we, 1);
    check("addi_pc", idex.pc_out, 32'h100);
    check("addi_aluop", idex.aluop, A_ADD);
    // Asynchronous reset in the middle of operation
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_valid", idex.out_valid, 0);
    check("arst_opv2", idex.opv2, 0);
    check("arst_waddr", idex.reg_waddr, 0);
    check("arst_we", idex.we, 0);
    check("arst_pc", idex.pc_out, 0);
    tick();
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1;
    tick();
    check("rel_valid", idex.out_valid, 1);
    check("rel_opv2", idex.opv2, 32'hFFFFFFFF);
    // x0 sources are never forwarded even with EX/MEM writing
    reg_data1 = 32'hAAAA0001;
    reg_data2 = 32'hBBBB0002;
    ex_we = 1'b1; ex_reg_waddr = 5'd1; ex_reg_wdata = 32'h11;
    mem_we = 1'b1; mem_reg_waddr = 5'd2; mem_reg_wdata = 32'h33;
    inst = I_ADD0;
    #1;
    check("x0_ready", in_ready, 1);
    tick();
    check("x0_opv1", idex.opv1, 0);
    check("x0_opv2", idex.opv2, 0);
    check("x0_waddr", idex.reg_waddr, 3);
    inst = I_ADD;
`ifdef STAGE_ID_FWD_EN
    #1;
    check("fwd_ready", in_ready, 1);
    tick();
    check("fwd_opv1_ex", idex.opv1, 32'h11);
    check("fwd_opv2_mem", idex.opv2, 32'h33);
    mem_reg_waddr = 5'd1;
    mem_reg_wdata = 32'h22;
    tick();
    check("fwd_ex_wins", idex.opv1, 32'h11);
    check("fwd_opv2_rf", idex.opv2, 32'hBBBB0002);
`else
    #1;
    check("raw_ex_stall", in_ready, 0);
    tick();
    check("raw_bubble", idex.out_valid, 0);
    ex_we = 1'b0;
    #1;
    check("raw_mem_stall", in_ready, 0);
    mem_we = 1'b0;
    #1;
    check("raw_clear", in_ready, 1);
    tick();
    check("raw_opv1_rf", idex.opv1, 32'hAAAA0001);
    check("raw_opv2_rf", idex.opv2, 32'hBBBB0002);
`endif
    // Load-use hazard: stall one cycle, bubble out, then take the MEM value
    side_idle();
    ex_we = 1'b1; ex_is_load = 1'b1; ex_reg_waddr = 5'd5; ex_reg_wdata = 32'hDEAD;
    reg_data1 = 32'h5555;
    reg_data2 = 32'h7777;
    inst = I_SUB;
    #1;
    check("lu_stall", in_ready, 0);
    tick();
    check("lu_bubble", idex.out_valid, 0);
    side_idle();
    mem_we = 1'b1; mem_reg_waddr = 5'd5; mem_reg_wdata = 32'h99;
`ifndef STAGE_ID_FWD_EN
    #1;
    check("lu_mem_stall", in_ready, 0);
    tick();
    mem_we = 1'b0;
    reg_data1 = 32'h99;
`endif
    #1;
    check("lu_ready", in_ready, 1);
    tick();
    check("lu_valid", idex.out_valid, 1);
    check("lu_opv1", idex.opv1, 32'h99);
    check("lu_opv2", idex.opv2, 32'h7777);
    check("lu_aluop", idex.aluop, A_SUB);
    check("lu_waddr", idex.reg_waddr, 6);
    // Backpressure: ORI held stable for three cycles
    side_idle();
    reg_data1 = 32'h1234;
    inst = I_ORI;
    tick();
    idex.out_ready = 1'b0;
    inst = I_ADDI;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", in_ready, 0);
      tick();
      check("bp_valid", idex.out_valid, 1);
      check("bp_opv1", idex.opv1, 32'h1234);
      check("bp_opv2", idex.opv2, 32'hFFFFFF00);
      check("bp_waddr", idex.reg_waddr, 2);
    end
    idex.out_ready = 1'b1;
    #1;
    check("bp_release", in_ready, 1);
    tick();
    check("bp_next_opv2", idex.opv2, 32'hFFFFFFFF);
    check("bp_next_waddr", idex.reg_waddr, 1);
    // Flush beats an incoming instruction
    flush = 1'b1;
    inst = I_ADD0;
    #1;
    check("fl_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    check("fl_valid", idex.out_valid, 0);
    check("fl_nocap", idex.reg_waddr, 1);
    // Back-to-back decode coverage, one capture per cycle
    pc = 32'h1000;
    inst = I_AUIPC;
    tick();
    check("auipc_valid", idex.out_valid, 1);
    check("auipc_opv1", idex.opv1, 32'h1000);
    check("auipc_opv2", idex.opv2, 32'h12345000);
    check("auipc_waddr", idex.reg_waddr, 4);
    pc = 32'h1004;
    inst = I_SW;
    reg_data1 = 32'h40;
    reg_data2 = 32'hCAFE;
    #1;
    check("sw_re", {re2, re1}, 2'b11);
    check("sw_addr2", reg_addr2, 2);
    tick();
    check("sw_valid", idex.out_valid, 1);
    check("sw_pc", idex.pc_out, 32'h1004);
    check("sw_imm", idex.imm, 32'hFFFFFFFC);
    check("sw_we", idex.we, 0);
    check("sw_opv1", idex.opv1, 32'h40);
    check("sw_opv2", idex.opv2, 32'hCAFE);
    inst = I_BAD;
    #1;
    check("bad_re", {re2, re1}, 2'b00);
    tick();
    check("bad_valid", idex.out_valid, 1);
    check("bad_illegal", idex.illegal, 1);
    check("bad_we", idex.we, 0);
    check("bad_aluop", idex.aluop, 0);
    inst = I_SLLI_BAD;
    tick();
    check("slli25_illegal", idex.illegal, 1);
    check("slli25_we", idex.we, 0);
    inst = I_SRAI;
    reg_data1 = 32'h80000000;
    tick();
    check("srai_illegal", idex.illegal, 0);
    check("srai_imm", idex.imm, 3);
    check("srai_opv1", idex.opv1, 32'h80000000);
    check("srai_alusel", idex.alusel, 3'd2);
    in_valid = 1'b0;
    tick();
    check("drain_valid", idex.out_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
